operand_loader: RTL and testbench
=================================

# operand_loader

Sequential front-end for the bitwise gate IP cores (nandgate and siblings). Accepts operands one word at a time over a single valid/ready input port and latches the first word as `a` and the second as `b`. It then presents both to the downstream combinational gate under a valid/ready handshake and captures the gate's result `c_in` into a held result register. An operation counter is maintained for board-level display.

## Interface

Parameters:
- `WIDTH`, default 8: operand and result width in bits; legal range 1–32.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clear`  in  1  synchronous soft clear; aborts the current operation.
- `din`  in  WIDTH  operand word.
- `din_valid`  in  1  `din` carries a word this cycle.
- `din_ready`  out  1  block accepts a word this cycle.
- `a`  out  WIDTH  latched first operand; drives the gate's `a` input.
- `b`  out  WIDTH  latched second operand; drives the gate's `b` input.
- `ab_valid`  out  1  `a`/`b` pair is complete and stable.
- `ab_ready`  in  1  downstream consumes the pair this cycle.
- `c_in`  in  WIDTH  combinational result from the gate.
- `result`  out  WIDTH  last captured result.
- `result_valid`  out  1  `result` holds a captured value.
- `op_count`  out  8  number of completed operations, modulo 256.

## Operation

The block is a three-state FSM with states LOAD_A, LOAD_B and ISSUE.
- **LOAD_A:** `din_ready`=1, `ab_valid`=0. On `din_valid`: `a`<=`din`, next state is LOAD_B.
- **LOAD_B:** `din_ready`=1, `ab_valid`=0. On `din_valid`: `b`<=`din`, next state is ISSUE.
- **ISSUE:** `din_ready`=0, `ab_valid`=1. `a` and `b` are held constant. On `ab_ready`:
  - `result`<=`c_in` (sampled in the handshake cycle).
  - `result_valid`<=1.
  - `op_count`<=`op_count`+1; wraps 255→0.
  - Next state is LOAD_A.

Output decoding:
- `din_ready` and `ab_valid` are decoded from state only (Moore). They have no combinational path from `din_valid` or `ab_ready`.

Priority per cycle, highest first:
1. `rst`: all state and outputs return to reset values.
2. `clear`: next state is LOAD_A; `result_valid`<=0; `op_count`<=0. `a`, `b` and `result` are unchanged. Any `din_valid` or `ab_ready` in the same cycle is ignored: no word is accepted and no result is captured.
3. Normal FSM transitions.

Held values:
- `result` and `result_valid` persist across subsequent operand loads and are overwritten only on the next ISSUE completion.
- `din` words offered in ISSUE are not consumed; the source must hold them until `din_ready`.
- `a` keeps its old value while in LOAD_B. `b` keeps its old value while in LOAD_A.

## Timing

Reset values (after any cycle with `rst`=1):
- State = LOAD_A.
- `a`=0, `b`=0, `result`=0, `result_valid`=0, `op_count`=0.
- `din_ready`=1, `ab_valid`=0.

Latency and throughput:
- Minimum latency is 3 cycles from the first `din` handshake to the result capture edge: A accept, B accept, ISSUE with `ab_ready`=1.
- `result`/`result_valid` are visible the cycle after the ISSUE handshake.
- Maximum throughput is one operation per 3 cycles.

Handshake rules:
- A transfer occurs on a rising edge where valid and ready are both 1.
- `ab_valid`, once asserted, stays high with `a`/`b` stable until the `ab_ready` handshake, `clear`, or `rst`.
- `c_in` must be valid combinationally in the ISSUE handshake cycle. The gate is purely combinational, so no extra wait is needed.

## Test plan

WIDTH=8, with nandgate instantiated as the consumer (`c_in` = ~(`a`&`b`)).
- Release `rst`; drive `din`=0xF0 then 0x3C with `din_valid`=1, `ab_ready`=1 → `ab_valid` high for one cycle with `a`=0xF0, `b`=0x3C; then `result`=0xCF, `result_valid`=1, `op_count`=1; `din_ready` low only during ISSUE.
- Load 0xFF, 0xFF with `ab_ready`=0 for 5 cycles, then 1 → `ab_valid` stays high 6 cycles with `a`/`b` stable, `din_ready`=0 throughout, `din_valid`=1 with 0xAA ignored; `result`=0x00 after the handshake.
- Load 0x0F only, then assert `clear` together with `din_valid` and 0x55 → state is LOAD_A, 0x55 not latched into `b`, `result_valid`=0, `op_count`=0.
- 256 back-to-back operations (0x00/0x00) → `op_count` goes 255→0; `result`=0xFF each time.
- Assert `rst` while in ISSUE with `ab_ready`=1 in the same cycle → no capture; all outputs equal their reset values the next cycle.
- Assert `din_valid` in LOAD_A with `din` toggling every cycle → exactly one word accepted per cycle, alternating into `a` then `b`.

Source files
------------

// File: rtl/operand_loader_if.sv
// Bus for operand_loader: the operand input stream, the a/b pair sent to the
// gate, the gate's result coming back, and the held result/counter outputs.
interface operand_loader_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ab_valid;
  logic             ab_ready;
  logic [WIDTH-1:0] c_in;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic [7:0]       op_count;

  // slave: the loader itself; master: operand source, gate and result sink
  modport slave (
    input  din, din_valid, ab_ready, c_in,
    output din_ready, a, b, ab_valid, result, result_valid, op_count
  );
  modport master (
    output din, din_valid, ab_ready, c_in,
    input  din_ready, a, b, ab_valid, result, result_valid, op_count
  );
endinterface

// File: rtl/operand_loader.sv
// Sequential front-end for the bitwise gate cores: loads a then b one word at
// a time, issues the pair downstream, and captures the gate result.
module operand_loader #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  operand_loader_if.slave bus
);
  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    ISSUE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic             result_valid_q;
  logic [7:0]       op_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= LOAD_A;
      a_q            <= '0;
      b_q            <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      op_count_q     <= '0;
    end else if (clear) begin
      // Abort: operands and last result are kept, handshakes this cycle are dropped.
      state          <= LOAD_A;
      result_valid_q <= 1'b0;
      op_count_q     <= '0;
    end else begin
      case (state)
        LOAD_A: if (bus.din_valid) begin
          a_q   <= bus.din;
          state <= LOAD_B;
        end
        LOAD_B: if (bus.din_valid) begin
          b_q   <= bus.din;
          state <= ISSUE;
        end
        ISSUE: if (bus.ab_ready) begin
          result_q       <= bus.c_in;
          result_valid_q <= 1'b1;
          op_count_q     <= op_count_q + 8'd1;
          state          <= LOAD_A;
        end
        default: state <= LOAD_A;
      endcase
    end
  end

  // Handshake outputs come from the state register only, never from the inputs.
  assign bus.din_ready    = (state != ISSUE);
  assign bus.ab_valid     = (state == ISSUE);
  assign bus.a            = a_q;
  assign bus.b            = b_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.op_count     = op_count_q;
endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with a NAND gate as the consumer.
module tb_operand_loader;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  logic clear;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  operand_loader_if #(.WIDTH(WIDTH)) bus ();

  operand_loader #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus)
  );

  assign bus.c_in = ~(bus.a & bus.b);

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0;
    bus.din = 8'h00; bus.din_valid = 1'b0; bus.ab_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    if (bus.a !== 8'h00) $display("FAIL reset_a got %h exp 00", bus.a); else pass_cnt++;
    total_cnt++;
    if (bus.b !== 8'h00) $display("FAIL reset_b got %h exp 00", bus.b); else pass_cnt++;
    total_cnt++;
    if (bus.result !== 8'h00) $display("FAIL reset_result got %h exp 00", bus.result); else pass_cnt++;
    total_cnt++;
    if ({bus.result_valid, bus.op_count} !== 9'h000)
      $display("FAIL reset_rv_cnt got %b/%h exp 0/00", bus.result_valid, bus.op_count);
    else pass_cnt++;
    total_cnt++;
    if ({bus.din_ready, bus.ab_valid} !== 2'b10)
      $display("FAIL reset_hs got %b exp 10", {bus.din_ready, bus.ab_valid});
    else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_basic();
    bus.din_valid = 1'b1; bus.ab_ready = 1'b1; bus.din = 8'hF0;
    step();
    if ({bus.din_ready, bus.ab_valid, bus.a} !== {2'b10, 8'hF0})
      $display("FAIL basic_loada got %b/%h exp 10/f0", {bus.din_ready, bus.ab_valid}, bus.a);
    else pass_cnt++;
    total_cnt++;
    bus.din = 8'h3C;
    step();
    if ({bus.din_ready, bus.ab_valid, bus.a, bus.b} !== {2'b01, 8'hF0, 8'h3C})
      $display("FAIL basic_issue got %b/%h/%h exp 01/f0/3c", {bus.din_ready, bus.ab_valid}, bus.a, bus.b);
    else pass_cnt++;
    total_cnt++;
    if (bus.result_valid !== 1'b0) $display("FAIL basic_rv_early got %b exp 0", bus.result_valid); else pass_cnt++;
    total_cnt++;
    bus.din_valid = 1'b0;
    step();
    if ({bus.result_valid, bus.result, bus.op_count} !== {1'b1, 8'hCF, 8'd1})
      $display("FAIL basic_result got %b/%h/%0d exp 1/cf/1", bus.result_valid, bus.result, bus.op_count);
    else pass_cnt++;
    total_cnt++;
    if ({bus.din_ready, bus.ab_valid} !== 2'b10)
      $display("FAIL basic_back_loada got %b exp 10", {bus.din_ready, bus.ab_valid});
    else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_stall();
    bus.ab_ready = 1'b0; bus.din_valid = 1'b1; bus.din = 8'hFF;
    step(); step();
    bus.din = 8'hAA;
    for (int i = 0; i < 6; i++) begin
      if ({bus.din_ready, bus.ab_valid, bus.a, bus.b} !== {2'b01, 8'hFF, 8'hFF})
        $display("FAIL stall_hold_%0d got %b/%h/%h exp 01/ff/ff", i, {bus.din_ready, bus.ab_valid}, bus.a, bus.b);
      else pass_cnt++;
      total_cnt++;
      if (i == 5) bus.ab_ready = 1'b1;
      else begin
        if ({bus.result, bus.op_count} !== {8'hCF, 8'd1})
          $display("FAIL stall_result_held got %h/%0d exp cf/1", bus.result, bus.op_count);
        else pass_cnt++;
        total_cnt++;
      end
      step();
    end
    bus.din_valid = 1'b0; bus.ab_ready = 1'b0;
    if ({bus.result_valid, bus.result, bus.op_count} !== {1'b1, 8'h00, 8'd2})
      $display("FAIL stall_result got %b/%h/%0d exp 1/00/2", bus.result_valid, bus.result, bus.op_count);
    else pass_cnt++;
    total_cnt++;
    if (bus.a !== 8'hFF) $display("FAIL stall_aa_ignored got %h exp ff", bus.a); else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_clear();
    bus.din_valid = 1'b1; bus.din = 8'h0F;
    step();
    clear = 1'b1; bus.din = 8'h55; bus.ab_ready = 1'b1;
    step();
    clear = 1'b0; bus.ab_ready = 1'b0;
    if ({bus.a, bus.b, bus.result} !== {8'h0F, 8'hFF, 8'h00})
      $display("FAIL clear_regs got %h/%h/%h exp 0f/ff/00", bus.a, bus.b, bus.result);
    else pass_cnt++;
    total_cnt++;
    if ({bus.result_valid, bus.op_count, bus.din_ready, bus.ab_valid} !== {1'b0, 8'd0, 2'b10})
      $display("FAIL clear_state got %b/%0d/%b exp 0/0/10", bus.result_valid, bus.op_count, {bus.din_ready, bus.ab_valid});
    else pass_cnt++;
    total_cnt++;
    // Next word must land in a, proving the FSM restarted in LOAD_A.
    bus.din = 8'h11;
    step();
    if ({bus.a, bus.b} !== {8'h11, 8'hFF}) $display("FAIL clear_restart got %h/%h exp 11/ff", bus.a, bus.b); else pass_cnt++;
    total_cnt++;
    bus.din = 8'h22;
    step();
    bus.din_valid = 1'b0; bus.ab_ready = 1'b1;
    step();
    bus.ab_ready = 1'b0;
    if ({bus.result, bus.op_count} !== {8'hFF, 8'd1})
      $display("FAIL clear_next_op got %h/%0d exp ff/1", bus.result, bus.op_count);
    else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_wrap();
    int bad = 0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    bus.din = 8'h00; bus.din_valid = 1'b1; bus.ab_ready = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      step(); step(); step();
      if (bus.result !== 8'hFF || bus.op_count !== 8'(i)) bad++;
      if (i == 255) begin
        if (bus.op_count !== 8'd255) $display("FAIL wrap_255 got %0d exp 255", bus.op_count); else pass_cnt++;
        total_cnt++;
      end
    end
    bus.din_valid = 1'b0; bus.ab_ready = 1'b0;
    if (bus.op_count !== 8'd0) $display("FAIL wrap_0 got %0d exp 0", bus.op_count); else pass_cnt++;
    total_cnt++;
    if (bad !== 0) $display("FAIL wrap_seq got %0d bad ops exp 0", bad); else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_rst_in_issue();
    bus.din_valid = 1'b1; bus.din = 8'h81;
    step(); step();
    if (bus.ab_valid !== 1'b1) $display("FAIL rsti_in_issue got %b exp 1", bus.ab_valid); else pass_cnt++;
    total_cnt++;
    bus.din_valid = 1'b0; bus.ab_ready = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; bus.ab_ready = 1'b0;
    if ({bus.a, bus.b, bus.result, bus.result_valid, bus.op_count} !== {8'h00, 8'h00, 8'h00, 1'b0, 8'd0})
      $display("FAIL rsti_regs got %h/%h/%h/%b/%0d exp 00/00/00/0/0", bus.a, bus.b, bus.result, bus.result_valid, bus.op_count);
    else pass_cnt++;
    total_cnt++;
    if ({bus.din_ready, bus.ab_valid} !== 2'b10)
      $display("FAIL rsti_hs got %b exp 10", {bus.din_ready, bus.ab_valid});
    else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_toggle();
    bus.din_valid = 1'b1; bus.ab_ready = 1'b0; bus.din = 8'h12;
    step();
    if ({bus.a, bus.b, bus.ab_valid} !== {8'h12, 8'h00, 1'b0})
      $display("FAIL toggle_a got %h/%h/%b exp 12/00/0", bus.a, bus.b, bus.ab_valid);
    else pass_cnt++;
    total_cnt++;
    bus.din = 8'h34;
    step();
    if ({bus.a, bus.b, bus.ab_valid} !== {8'h12, 8'h34, 1'b1})
      $display("FAIL toggle_b got %h/%h/%b exp 12/34/1", bus.a, bus.b, bus.ab_valid);
    else pass_cnt++;
    total_cnt++;
    bus.din = 8'h56;
    step();
    if ({bus.a, bus.b} !== {8'h12, 8'h34}) $display("FAIL toggle_held got %h/%h exp 12/34", bus.a, bus.b); else pass_cnt++;
    total_cnt++;
    bus.din_valid = 1'b0; bus.ab_ready = 1'b1;
    step();
    bus.ab_ready = 1'b0;
    if ({bus.result, bus.op_count} !== {8'hEF, 8'd1})
      $display("FAIL toggle_result got %h/%0d exp ef/1", bus.result, bus.op_count);
    else pass_cnt++;
    total_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_clear();
    test_wrap();
    test_rst_in_issue();
    test_toggle();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
